// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: reset PC, fetch state encoding,
// next-PC select codes and word-PC helpers.
package mips_pkg;

    localparam int          WORD_PC_W    = 30;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_SEL_PCP4   = 2'd0,
        NPC_SEL_BRANCH = 2'd1,
        NPC_SEL_JUMP   = 2'd2,
        NPC_SEL_JR     = 2'd3
    } npc_sel_e;

    // Word-address increment; wraps silently at the top of the 30-bit space.
    function automatic logic [WORD_PC_W-1:0] word_pc_inc(input logic [WORD_PC_W-1:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_fsm.sv
// Fetch sequencing FSM: state register plus next-state logic with redirect
// taking priority over grant, response and decode handshake.
//  state | meaning
//  REQ   | request driven on imem, waiting for gnt
//  WAIT  | request granted, waiting for rvalid
//  HOLD  | instruction presented to decode, waiting for id_ready
//  DROP  | response still owed for a redirected fetch; discard it
module pc_fetch_fsm
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         redir_valid_i,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic         id_ready_i,
    output fetch_state_e state_o,
    output logic         capture_o,
    output logic         handshake_o
);

    fetch_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FS_REQ;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        capture_o   = 1'b0;
        handshake_o = 1'b0;
        case (state_q)
            FS_REQ: begin
                if (redir_valid_i)   state_d = imem_gnt_i ? FS_DROP : FS_REQ;
                else if (imem_gnt_i) state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (redir_valid_i) begin
                    state_d = imem_rvalid_i ? FS_REQ : FS_DROP;
                end else if (imem_rvalid_i) begin
                    state_d   = FS_HOLD;
                    capture_o = 1'b1;
                end
            end
            FS_HOLD: begin
                if (redir_valid_i) begin
                    state_d = FS_REQ;
                end else if (id_ready_i) begin
                    state_d     = FS_REQ;
                    handshake_o = 1'b1;
                end
            end
            FS_DROP: begin
                // The owed response is consumed whether or not another redirect arrives.
                if (imem_rvalid_i) state_d = FS_REQ;
            end
            default: state_d = FS_REQ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, issues one imem request at a time, presents
// {instr, pc, pcp4} to decode. PC_FETCH_CNT_EN adds the fetch_cnt handshake counter.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] npc,
    input  logic        redir_valid,
    input  logic [29:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcp4
`ifdef PC_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam logic [WORD_PC_W-1:0] RESET_WPC = RESET_PC[31:2];

    fetch_state_e         state;
    logic                 capture, handshake;
    logic [WORD_PC_W-1:0] pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;

    pc_fetch_fsm u_fsm (
        .clk           (clk),
        .rst           (rst),
        .redir_valid_i (redir_valid),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .id_ready_i    (id_ready),
        .state_o       (state),
        .capture_o     (capture),
        .handshake_o   (handshake)
    );

    always_comb begin
        pc_d = pc_q;
        if (redir_valid)    pc_d = redir_pc;
        else if (handshake) pc_d = npc;
        instr_d = capture ? imem_rdata : instr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_WPC;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // The fetch address and the decode PC are the same register by design.
    assign imem_req  = (state == FS_REQ) && !rst;
    assign imem_addr = {pc_q, 2'b00};
    assign id_valid  = (state == FS_HOLD) && !rst;
    assign id_instr  = instr_q;
    assign id_pc     = {pc_q, 2'b00};
    assign id_pcp4   = {word_pc_inc(pc_q), 2'b00};

`ifdef PC_FETCH_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)            cnt_q <= '0;
        else if (handshake) cnt_q <= cnt_q + 32'd1;
    end

    assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: stimulus pushes expected grants and decode
// tuples; a negedge monitor pops and compares. Build with PC_FETCH_CNT_EN for counter checks.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] npc;
    logic        redir_valid;
    logic [29:0] redir_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcp4;
`ifdef PC_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int hs_model = 0;

    logic [31:0] exp_req_q[$];
    logic [95:0] exp_id_q[$];

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pcp4     (id_pcp4)
`ifdef PC_FETCH_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef PC_FETCH_CNT_EN
        chk(name, fetch_cnt, hs_model);
`else
        if (name.len() == 0) $display("unnamed counter check");
`endif
    endtask

    // Monitor: a granted request pops the address queue, a decode handshake pops the tuple queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_gnt) begin
                if (exp_req_q.size() == 0) begin
                    chk("unexpected_grant_addr", imem_addr, 32'hxxxx_xxxx);
                end else begin
                    chk("grant_addr", imem_addr, exp_req_q.pop_front());
                end
            end
            if (id_valid && id_ready && !redir_valid) begin
                if (exp_id_q.size() == 0) begin
                    chk("unexpected_handshake_instr", id_instr, 32'hxxxx_xxxx);
                end else begin
                    logic [95:0] e;
                    e = exp_id_q.pop_front();
                    chk("hs_instr", id_instr, e[95:64]);
                    chk("hs_pc",    id_pc,    e[63:32]);
                    chk("hs_pcp4",  id_pcp4,  e[31:0]);
                end
            end
        end
    end

    // Called just after a rising edge with the DUT in REQ at addr.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input logic [29:0] nxt, input int stall);
        exp_req_q.push_back(addr);
        exp_id_q.push_back({data, addr, addr + 32'd4});
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        id_ready    = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_id_valid", {31'd0, id_valid}, 32'd1);
            chk("stall_imem_req", {31'd0, imem_req}, 32'd0);
            chk("stall_id_instr", id_instr, data);
            chk("stall_id_pc",    id_pc,    addr);
            @(posedge clk); #1;
        end
        id_ready = 1'b1;
        npc      = nxt;
        @(posedge clk); #1;
        id_ready = 1'b0;
        hs_model++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; npc = '0; redir_valid = 1'b0; redir_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0; id_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0000_3000);
        hs_model = 0;
        chk_cnt("rst_fetch_cnt");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: immediate grant, response next cycle
        do_fetch(32'h0000_3000, 32'h2408_0005, 30'h0C00, 0);
        // 2: back-pressure then npc 0x0C01
        do_fetch(32'h0000_3000, 32'h1111_2222, 30'h0C01, 5);
        @(negedge clk);
        chk("after_bp_addr", imem_addr, 32'h0000_3004);

        // 3: redirect while waiting for the response
        @(posedge clk); #1;
        exp_req_q.push_back(32'h0000_3004);
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 30'h0000_0060;
        id_ready    = 1'b1;
        @(posedge clk); #1;
        redir_valid = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("drop_id_valid", {31'd0, id_valid}, 32'd0);
        chk("drop_imem_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        id_ready    = 1'b0;

        // 4: grant withheld for 4 cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nogrant_req",   {31'd0, imem_req}, 32'd1);
            chk("nogrant_addr",  imem_addr, 32'h0000_0180);
            chk("nogrant_valid", {31'd0, id_valid}, 32'd0);
            @(posedge clk); #1;
        end
        do_fetch(32'h0000_0180, 32'h0000_0180, 30'h0000_0061, 1);

        // 5: reset mid-fetch, stale rvalid afterwards
        exp_req_q.push_back(32'h0000_0184);
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        hs_model = 0;
        @(negedge clk);
        chk("midrst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_id_instr", id_instr, 32'd0);
        chk_cnt("midrst_fetch_cnt");
        @(posedge clk); #1;
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        @(negedge clk);
        chk("stale_req",  {31'd0, imem_req}, 32'd1);
        chk("stale_addr", imem_addr, 32'h0000_3000);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("stale_id_valid", {31'd0, id_valid}, 32'd0);
        chk("stale_req2",     {31'd0, imem_req}, 32'd1);
        @(posedge clk); #1;
        do_fetch(32'h0000_3000, 32'h3C01_0000, 30'h100, 0);

        // 6: ten sequential handshakes, then a redirect in HOLD
        for (int i = 0; i < 10; i++) begin
            do_fetch({30'h100 + 30'(i), 2'b00}, 32'hA000_0000 + 32'(i), 30'h100 + 30'(i + 1), i % 2);
        end
        chk_cnt("cnt_after_11");
        exp_req_q.push_back(32'h0000_0428);
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_AAAA;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 30'h3FFF_FFFF;
        id_ready    = 1'b1;
        npc         = 30'h0000_0777;
        @(posedge clk); #1;
        redir_valid = 1'b0;
        id_ready    = 1'b0;
        @(negedge clk);
        chk("redir_hold_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_hold_addr",  imem_addr, 32'hFFFF_FFFC);
        chk_cnt("redir_hold_cnt");
        @(posedge clk); #1;

        // Top-of-space wrap
        do_fetch(32'hFFFF_FFFC, 32'h0800_0000, 30'h0, 0);
        do_fetch(32'h0000_0000, 32'h0000_0001, 30'h5, 0);
        @(negedge clk);
        chk("wrap_next_addr", imem_addr, 32'h0000_0014);
        chk_cnt("final_cnt");
        chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        chk("id_queue_drained",  32'(exp_id_q.size()),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
